// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux_arb_pkg;

  // Default width of each requester data word.
  localparam int unsigned DEF_DATA_W = 8;

  // Requester count; the 2-bit select only covers four requesters.
  localparam int unsigned DEF_N_REQ = 4;

  // Width of the completed-handshake counter.
  localparam int unsigned GRANT_CNT_W = 16;

  // Arbiter states: IDLE looks for a winner, HOLD presents it downstream.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Select index that follows idx in round-robin order.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit found by
// scanning from ptr upwards, wrapping modulo 4.
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_idx,
  output logic       any
);

  logic [1:0] idx;
  logic       found;

  // Scan the four positions in priority order starting at ptr.
  always_comb begin
    gnt_idx = 2'd0;
    found   = 1'b0;
    idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter feeding an external mux. One requester is accepted per
// IDLE cycle, its word is registered and held until downstream accepts it.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_REQ  = DEF_N_REQ
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              in_valid,
  input  logic [N_REQ-1:0][DATA_W-1:0]  in_data,
  output logic [N_REQ-1:0]              in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [1:0]                    out_sel,
  output logic [GRANT_CNT_W-1:0]        grant_cnt
);

  arb_state_e              state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [1:0]              out_sel_q, out_sel_d;
  logic [GRANT_CNT_W-1:0]  grant_cnt_q;
  logic                    cnt_en;
  logic                    grant;

  logic [3:0]              req;
  logic [1:0]              gnt_idx;
  logic                    any_req;

  assign req = 4'(in_valid);

  rr_pick u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  // Next-state logic: grant in IDLE, wait for the downstream handshake in HOLD.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    cnt_en     = 1'b0;
    grant      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant      = 1'b1;
          out_data_d = in_data[gnt_idx];
          out_sel_d  = gnt_idx;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Pointer only moves once the word is actually delivered.
        if (out_ready) begin
          ptr_d   = next_idx(out_sel_q);
          cnt_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept pulse to the winner; gated by reset so nothing is accepted while held.
  always_comb begin
    in_ready = '0;
    if (grant && rst_n) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // State, pointer and output data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      out_data_q <= '0;
      out_sel_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
    end
  end

  // Completed-handshake counter; wraps naturally at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else if (cnt_en) begin
      grant_cnt_q <= grant_cnt_q + 1'b1;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter.
module tb_mux_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [3:0][7:0]  in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [1:0]       out_sel;
  logic [15:0]      grant_cnt;

  int vectors;
  int miscompares;

  mux_arbiter #(
    .DATA_W (8),
    .N_REQ  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: pulse reset for two cycles, leave inputs idle.
  task automatic apply_reset();
    @(negedge clk);
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_in_ready cyc%0d got %b want 0000", c, in_ready);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out_valid cyc%0d got %b want 0", c, out_valid);
      end
      vectors++;
      if (grant_cnt !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_grant_cnt cyc%0d got %h want 0000", c, grant_cnt);
      end
      vectors++;
      if (out_data !== 8'h00 || out_sel !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_out_regs cyc%0d got data=%h sel=%0d want 00/0", c, out_data, out_sel);
      end
    end
    in_valid = 4'b0000;
    rst_n    = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_idle();
    @(negedge clk);
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || grant_cnt !== 16'd0 || in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_out_ready got valid=%b cnt=%0d rdy=%b want 0/0/0000",
               out_valid, grant_cnt, in_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    in_data   = {8'h5A, 8'hA5, 8'h12, 8'h34};
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_in_ready got %b want 0100", in_ready);
    end
    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_output got valid=%b sel=%0d data=%h want 1/2/a5",
               out_valid, out_sel, out_data);
    end
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_ready_pulse got %b want 0000", in_ready);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || grant_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL single_done got valid=%b cnt=%0d want 0/1", out_valid, grant_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel;
    logic [3:0] exp_rdy;
    apply_reset();
    in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_sel = 2'(k % 4);
      exp_rdy = 4'b0001 << exp_sel;
      #1;
      vectors++;
      if (in_ready !== exp_rdy || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_grant%0d got rdy=%b valid=%b want %b/0", k, in_ready, out_valid, exp_rdy);
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== in_data[exp_sel]) begin
        miscompares++;
        $display("FAIL rr_out%0d got valid=%b sel=%0d data=%h want 1/%0d/%h",
                 k, out_valid, out_sel, out_data, exp_sel, in_data[exp_sel]);
      end
      @(negedge clk);
    end
    in_valid = 4'b0000;
    vectors++;
    if (grant_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL rr_count got %0d want 5", grant_cnt);
    end
  endtask

  task automatic test_backpressure();
    // Pointer is 1 here: the last round-robin grant went to requester 0.
    @(negedge clk);
    in_data   = {8'h99, 8'h88, 8'h3C, 8'h77};
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_grant got %b want 0010", in_ready);
    end
    @(negedge clk);
    in_valid = 4'b1111;
    in_data  = {8'h99, 8'h88, 8'hFF, 8'h77};
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd1 || in_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold%0d got valid=%b data=%h sel=%0d rdy=%b want 1/3c/1/0000",
                 c, out_valid, out_data, out_sel, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || grant_cnt !== 16'd6) begin
      miscompares++;
      $display("FAIL bp_handshake got valid=%b cnt=%0d want 0/6", out_valid, grant_cnt);
    end
    // With all requesting, the winner reveals the pointer (expected 2).
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_ptr got rdy=%b want 0100", in_ready);
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    in_data   = {8'h77, 8'h66, 8'h55, 8'h44};
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 4'b0000;
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 8'h77) begin
      miscompares++;
      $display("FAIL mr_hold got valid=%b sel=%0d data=%h want 1/3/77", out_valid, out_sel, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 ||
        grant_cnt !== 16'd0 || in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL mr_async got valid=%b data=%h sel=%0d cnt=%0d rdy=%b want 0/00/0/0/0000",
               out_valid, out_data, out_sel, grant_cnt, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL mr_restart got rdy=%b want 0001", in_ready);
    end
    @(negedge clk);
    in_valid = 4'b0000;
    vectors++;
    if (out_sel !== 2'd0 || out_data !== 8'h44) begin
      miscompares++;
      $display("FAIL mr_first got sel=%0d data=%h want 0/44", out_sel, out_data);
    end
    @(negedge clk);
    vectors++;
    if (grant_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL mr_count got %0d want 1", grant_cnt);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    force dut.grant_cnt_q = 16'hFFFF;
    #1;
    release dut.grant_cnt_q;
    #1;
    vectors++;
    if (grant_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_preload got %h want ffff", grant_cnt);
    end
    @(negedge clk);
    in_data   = {8'h04, 8'h03, 8'h02, 8'h01};
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 4'b0000;
    @(negedge clk);
    vectors++;
    if (grant_cnt !== 16'h0000 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_count got cnt=%h valid=%b want 0000/0", grant_cnt, out_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 4'b0000;
    in_data     = '0;
    out_ready   = 1'b0;
    test_reset();
    test_idle();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of each requester data word and of out_data.
REQ-002 Parameter N_REQ, default 4, number of requesters; only 4 is supported, matching a 2-bit select.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  N_REQ  per-requester request; bit i qualifies in_data[i].
REQ-006 in_data  input  N_REQ x DATA_W  per-requester data word.
REQ-007 in_ready  output  N_REQ  per-requester accept pulse; at most one bit high.
REQ-008 out_valid  output  1  granted word present on out_data.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 out_data  output  DATA_W  registered data of the granted requester.
REQ-011 out_sel  output  2  index of the granted requester; drives the mux select.
REQ-012 grant_cnt  output  16  count of completed output handshakes; wraps from 0xFFFF to 0.

Function
REQ-013 State machine states: IDLE and HOLD.
REQ-014 IDLE, no in_valid bit set -> stay in IDLE; outputs unchanged; out_valid=0.
REQ-015 IDLE, any in_valid bit set -> pick winner g by round-robin from pointer ptr: first set bit scanning ptr, ptr+1, ... mod 4.
REQ-016 Grant cycle actions:
- in_ready[g]=1 for exactly that one cycle;
- register out_data<=in_data[g] and out_sel<=g;
- go to HOLD.
REQ-017 out_valid=1 in the cycle after in_valid is sampled; latency is 1 cycle.
REQ-018 HOLD: out_valid=1; out_data and out_sel stay stable; in_ready=0.
REQ-019 HOLD, out_ready=1 -> handshake completes:
- out_valid=0 next cycle;
- ptr<=(g+1) mod 4;
- grant_cnt<=grant_cnt+1;
- go to IDLE.
REQ-020 HOLD, out_ready=0 -> stay in HOLD for any number of cycles; no requester is accepted.
REQ-021 Peak throughput is one word per 2 cycles; out_valid is never high in two consecutive handshake cycles.
REQ-022 in_valid changes while in HOLD are ignored until the return to IDLE.
REQ-023 A requester holds in_valid and in_data until its in_ready pulse; the arbiter does not check this.
REQ-024 out_ready high while in IDLE has no effect.
REQ-025 ptr advances only on a completed handshake, never on a grant alone.

Reset
REQ-026 While rst_n=0, state at reset values regardless of clk:
- state=IDLE, ptr=0;
- out_valid=0, out_data=0, out_sel=0;
- in_ready=0, grant_cnt=0.
REQ-027 Reset asserted mid-HOLD discards the pending word; that word is not counted.
REQ-028 The first grant after reset deassertion takes effect no earlier than the first posedge with rst_n=1.

Structure
REQ-029 Package mux_arb_pkg holds:
- the state enum (IDLE, HOLD);
- N_REQ, DATA_W defaults;
- the grant-count width constant (16).
REQ-030 Sub-module rr_pick: combinational; inputs req[3:0] and ptr[1:0]; outputs gnt_idx[1:0] and any.
REQ-031 The mux datapath is outside this block; out_sel drives its select.

Verification
REQ-032 Reset check: rst_n=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, grant_cnt=0 throughout.
REQ-033 Single request: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 ->
- in_ready=4'b0100 for 1 cycle;
- next cycle out_valid=1, out_sel=2, out_data=8'hA5;
- one cycle later out_valid=0 and grant_cnt=1.
REQ-034 Round-robin: in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0 on successive handshakes.
REQ-035 Backpressure: grant requester 1 with data 8'h3C, out_ready=0 for 5 cycles ->
- out_valid=1, out_data=8'h3C, out_sel=1 stable throughout;
- in_ready=0 throughout;
- on out_ready=1, one handshake, then ptr=2.
REQ-036 Mid-operation reset: assert rst_n=0 in HOLD -> outputs return to reset values asynchronously; grant_cnt=0; the next grant starts from requester 0.
REQ-037 Counter wrap: preload grant_cnt to 0xFFFF by force or run, then complete one handshake -> grant_cnt=0.
